// File: rtl/atm_pkg.sv
`default_nettype none
// ==========================================================================
// atm_pkg : state/opcode/status types and datapath widths for the ATM block
// Rev 1.0
// ==========================================================================
package atm_pkg;

  localparam int ACC_W = 17;
  localparam int PIN_W = 17;
  localparam int AMT_W = 19;

  localparam logic [2:0] OP_BAL  = 3'd0;
  localparam logic [2:0] OP_WDR  = 3'd1;
  localparam logic [2:0] OP_DEP  = 3'd2;
  localparam logic [2:0] OP_XFR  = 3'd3;
  localparam logic [2:0] OP_CPIN = 3'd4;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_LANG   = 4'd1,
    ST_PIN    = 4'd2,
    ST_MENU   = 4'd3,
    ST_BAL    = 4'd4,
    ST_WDR    = 4'd5,
    ST_DEP    = 4'd6,
    ST_XFR    = 4'd7,
    ST_CPIN   = 4'd8,
    ST_RCPT   = 4'd9,
    ST_MORE   = 4'd10,
    ST_FINISH = 4'd11
  } state_e;

  typedef struct packed {
    logic xfr;
    logic fin;
    logic bal;
    logic dep;
    logic wdr;
    logic pin;
    logic rcpt;
  } status_t;

  // Carry-out sum: bit AMT_W set means the result does not fit a balance
  function automatic logic [AMT_W:0] wide_add(input logic [AMT_W-1:0] a,
                                              input logic [AMT_W-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

endpackage
`default_nettype wire

// File: rtl/atm_if.sv
`default_nettype none
// ==========================================================================
// atm_if : front-panel operands in, one-cycle status pulses out
// Rev 1.0
// ==========================================================================
interface atm_if;
  import atm_pkg::*;

  logic             Card_in;
  logic             Language;
  logic             Timer;
  logic             money_counting;
  logic             another_transaction_bit;
  logic [2:0]       opcode;
  logic [PIN_W-1:0] password;
  logic [PIN_W-1:0] new_pin;
  logic             allowwithdraw;
  logic             take_receipt;
  logic             allow_transfer;
  logic [ACC_W-1:0] Pers_Account_No;
  logic [ACC_W-1:0] ur_account;
  logic [AMT_W-1:0] withdraw_amount;
  logic [AMT_W-1:0] Transfer_Amount;
  logic [AMT_W-1:0] deposit_amount;

  logic Transfer_Successfully;
  logic ATM_Usage_Finished;
  logic Balance_Shown;
  logic Deposited_Successfully;
  logic Withdrew_Successfully;
  logic Pin_Changed_Successfully;
  logic Receipt_Printed;

  modport master (
    output Card_in, Language, Timer, money_counting, another_transaction_bit,
           opcode, password, new_pin, allowwithdraw, take_receipt, allow_transfer,
           Pers_Account_No, ur_account, withdraw_amount, Transfer_Amount, deposit_amount,
    input  Transfer_Successfully, ATM_Usage_Finished, Balance_Shown,
           Deposited_Successfully, Withdrew_Successfully, Pin_Changed_Successfully,
           Receipt_Printed
  );

  modport slave (
    input  Card_in, Language, Timer, money_counting, another_transaction_bit,
           opcode, password, new_pin, allowwithdraw, take_receipt, allow_transfer,
           Pers_Account_No, ur_account, withdraw_amount, Transfer_Amount, deposit_amount,
    output Transfer_Successfully, ATM_Usage_Finished, Balance_Shown,
           Deposited_Successfully, Withdrew_Successfully, Pin_Changed_Successfully,
           Receipt_Printed
  );

endinterface
`default_nettype wire

// File: rtl/atm_account_table.sv
`default_nettype none
// ==========================================================================
// atm_account_table : account register file, two number lookups, pair write
// Rev 1.0
// ==========================================================================
module atm_account_table
  import atm_pkg::*;
#(
  parameter int               NUM_ACCOUNTS = 4,
  parameter logic [ACC_W-1:0] ACC_BASE     = 17'd1000,
  parameter logic [PIN_W-1:0] PIN_BASE     = 17'd1234,
  parameter logic [AMT_W-1:0] INIT_BALANCE = 19'd50000,
  parameter int               IDX_W        = $clog2(NUM_ACCOUNTS)
) (
  input  logic             clk,
  input  logic             reset,
  // lookup A: session account number
  input  logic [ACC_W-1:0] lka_num_i,
  output logic             lka_hit_o,
  output logic [IDX_W-1:0] lka_idx_o,
  output logic [PIN_W-1:0] lka_pin_o,
  // lookup B: transfer destination
  input  logic [ACC_W-1:0] lkb_num_i,
  output logic             lkb_hit_o,
  output logic [IDX_W-1:0] lkb_idx_o,
  output logic [AMT_W-1:0] lkb_bal_o,
  // latched source entry
  input  logic [IDX_W-1:0] src_idx_i,
  output logic [AMT_W-1:0] src_bal_o,
  output logic [PIN_W-1:0] src_pin_o,
  // writes
  input  logic             bal_we_a_i,
  input  logic [IDX_W-1:0] bal_idx_a_i,
  input  logic [AMT_W-1:0] bal_a_i,
  input  logic             bal_we_b_i,
  input  logic [IDX_W-1:0] bal_idx_b_i,
  input  logic [AMT_W-1:0] bal_b_i,
  input  logic             pin_we_i,
  input  logic [IDX_W-1:0] pin_idx_i,
  input  logic [PIN_W-1:0] pin_i
);

  logic [AMT_W-1:0] bal_q [NUM_ACCOUNTS];
  logic [PIN_W-1:0] pin_q [NUM_ACCOUNTS];

  // Account numbers are fixed, so a lookup is a compare against each constant
  always_comb begin : p_lookup
    lka_hit_o = 1'b0;
    lka_idx_o = '0;
    lkb_hit_o = 1'b0;
    lkb_idx_o = '0;
    for (int i = 0; i < NUM_ACCOUNTS; i++) begin
      if (lka_num_i == (ACC_BASE + ACC_W'(i))) begin
        lka_hit_o = 1'b1;
        lka_idx_o = IDX_W'(i);
      end
      if (lkb_num_i == (ACC_BASE + ACC_W'(i))) begin
        lkb_hit_o = 1'b1;
        lkb_idx_o = IDX_W'(i);
      end
    end
  end

  assign lka_pin_o = pin_q[lka_idx_o];
  assign lkb_bal_o = bal_q[lkb_idx_o];
  assign src_bal_o = bal_q[src_idx_i];
  assign src_pin_o = pin_q[src_idx_i];

  always_ff @(posedge clk or posedge reset) begin : p_table
    if (reset) begin
      for (int i = 0; i < NUM_ACCOUNTS; i++) begin
        bal_q[i] <= INIT_BALANCE;
        pin_q[i] <= PIN_BASE + PIN_W'(i);
      end
    end else begin
      if (bal_we_a_i) bal_q[bal_idx_a_i] <= bal_a_i;
      if (bal_we_b_i) bal_q[bal_idx_b_i] <= bal_b_i;
      if (pin_we_i)   pin_q[pin_idx_i]   <= pin_i;
    end
  end

endmodule
`default_nettype wire

// File: rtl/atm.sv
`default_nettype none
// ==========================================================================
// atm : card-session controller (login, menu, receipt); ATM_DAILY_LIMIT_EN
//       adds a per-session withdraw cap.  Rev 1.0
// ==========================================================================
module atm
  import atm_pkg::*;
#(
  parameter int               NUM_ACCOUNTS  = 4,
  parameter logic [ACC_W-1:0] ACC_BASE      = 17'd1000,
  parameter logic [PIN_W-1:0] PIN_BASE      = 17'd1234,
  parameter logic [AMT_W-1:0] INIT_BALANCE  = 19'd50000,
  parameter int               MAX_PIN_TRIES = 3
`ifdef ATM_DAILY_LIMIT_EN
  ,
  parameter logic [AMT_W-1:0] DAILY_LIMIT   = 19'd20000
`endif
) (
  input  logic clk,
  input  logic reset,
  atm_if.slave bus
);

  localparam int               IDX_W    = $clog2(NUM_ACCOUNTS);
  localparam int               TRY_W    = $clog2(MAX_PIN_TRIES + 1);
  localparam logic [TRY_W-1:0] TRY_LAST = TRY_W'(MAX_PIN_TRIES - 1);

  state_e           state_q, state_d;
  logic             card_q;
  logic             lang_q, lang_d;
  logic [TRY_W-1:0] tries_q, tries_d;
  logic [IDX_W-1:0] src_q, src_d;
  status_t          status_q, status_d;

  logic             w_a_hit, w_b_hit;
  logic [IDX_W-1:0] w_a_idx, w_b_idx;
  logic [PIN_W-1:0] w_a_pin, w_src_pin;
  logic [AMT_W-1:0] w_b_bal, w_src_bal;
  logic             w_bal_we_a, w_bal_we_b, w_pin_we;
  logic [AMT_W-1:0] w_bal_a, w_bal_b;

  logic             w_abort, w_pin_ok, w_limit_ok;
  logic             w_wdr_ok, w_dep_ok, w_xfr_ok, w_cpin_ok;
  logic [AMT_W:0]   w_dep_sum, w_xfr_sum;
  logic             w_unused_lang;

  atm_account_table #(
    .NUM_ACCOUNTS (NUM_ACCOUNTS),
    .ACC_BASE     (ACC_BASE),
    .PIN_BASE     (PIN_BASE),
    .INIT_BALANCE (INIT_BALANCE),
    .IDX_W        (IDX_W)
  ) u_table (
    .clk         (clk),
    .reset       (reset),
    .lka_num_i   (bus.Pers_Account_No),
    .lka_hit_o   (w_a_hit),
    .lka_idx_o   (w_a_idx),
    .lka_pin_o   (w_a_pin),
    .lkb_num_i   (bus.ur_account),
    .lkb_hit_o   (w_b_hit),
    .lkb_idx_o   (w_b_idx),
    .lkb_bal_o   (w_b_bal),
    .src_idx_i   (src_q),
    .src_bal_o   (w_src_bal),
    .src_pin_o   (w_src_pin),
    .bal_we_a_i  (w_bal_we_a),
    .bal_idx_a_i (src_q),
    .bal_a_i     (w_bal_a),
    .bal_we_b_i  (w_bal_we_b),
    .bal_idx_b_i (w_b_idx),
    .bal_b_i     (w_bal_b),
    .pin_we_i    (w_pin_we),
    .pin_idx_i   (src_q),
    .pin_i       (bus.new_pin)
  );

  // Card removal or timeout ends any live session and suppresses its commit
  assign w_abort = (state_q != ST_IDLE) && (state_q != ST_FINISH) &&
                   (bus.Timer || !bus.Card_in);

  assign w_pin_ok  = w_a_hit && (bus.password == w_a_pin);
  assign w_dep_sum = wide_add(w_src_bal, bus.deposit_amount);
  assign w_xfr_sum = wide_add(w_b_bal, bus.Transfer_Amount);

  assign w_wdr_ok  = bus.allowwithdraw && (bus.withdraw_amount != '0) &&
                     (bus.withdraw_amount <= w_src_bal) && w_limit_ok;
  assign w_dep_ok  = (bus.deposit_amount != '0) && !w_dep_sum[AMT_W];
  assign w_xfr_ok  = bus.allow_transfer && w_b_hit && (w_b_idx != src_q) &&
                     (bus.Transfer_Amount != '0) &&
                     (bus.Transfer_Amount <= w_src_bal) && !w_xfr_sum[AMT_W];
  assign w_cpin_ok = (bus.new_pin != '0) && (bus.new_pin != w_src_pin);

  // Language is held for the front panel only; nothing here depends on it
  assign w_unused_lang = lang_q;

`ifdef ATM_DAILY_LIMIT_EN
  logic [AMT_W-1:0] total_q, total_d;
  logic [AMT_W:0]   w_total_sum;

  assign w_total_sum = wide_add(total_q, bus.withdraw_amount);
  assign w_limit_ok  = (w_total_sum <= {1'b0, DAILY_LIMIT});

  always_comb begin : p_total
    total_d = total_q;
    if (state_q == ST_IDLE) begin
      total_d = '0;
    end else if ((state_q == ST_WDR) && !w_abort && w_wdr_ok) begin
      total_d = w_total_sum[AMT_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin : p_total_reg
    if (reset) total_q <= '0;
    else       total_q <= total_d;
  end
`else
  assign w_limit_ok = 1'b1;
`endif

  always_ff @(posedge clk or posedge reset) begin : p_state
    if (reset) begin
      state_q  <= ST_IDLE;
      card_q   <= 1'b0;
      lang_q   <= 1'b0;
      tries_q  <= '0;
      src_q    <= '0;
      status_q <= '0;
    end else begin
      state_q  <= state_d;
      card_q   <= bus.Card_in;
      lang_q   <= lang_d;
      tries_q  <= tries_d;
      src_q    <= src_d;
      status_q <= status_d;
    end
  end

  always_comb begin : p_next
    state_d = state_q;
    if (w_abort) begin
      state_d = ST_FINISH;
    end else begin
      case (state_q)
        ST_IDLE:   if (bus.Card_in && !card_q) state_d = ST_LANG;
        ST_LANG:   state_d = ST_PIN;
        ST_PIN: begin
          if (w_pin_ok)                state_d = ST_MENU;
          else if (tries_q == TRY_LAST) state_d = ST_FINISH;
        end
        ST_MENU: begin
          case (bus.opcode)
            OP_BAL:  state_d = ST_BAL;
            OP_WDR:  state_d = ST_WDR;
            OP_DEP:  state_d = ST_DEP;
            OP_XFR:  state_d = ST_XFR;
            OP_CPIN: state_d = ST_CPIN;
            default: state_d = ST_MENU;
          endcase
        end
        ST_BAL, ST_WDR, ST_XFR, ST_CPIN: state_d = ST_RCPT;
        ST_DEP:    if (!bus.money_counting) state_d = ST_RCPT;
        ST_RCPT:   state_d = ST_MORE;
        ST_MORE:   state_d = bus.another_transaction_bit ? ST_MENU : ST_FINISH;
        ST_FINISH: state_d = ST_IDLE;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin : p_out
    status_d   = '0;
    tries_d    = tries_q;
    src_d      = src_q;
    lang_d     = lang_q;
    w_bal_we_a = 1'b0;
    w_bal_a    = '0;
    w_bal_we_b = 1'b0;
    w_bal_b    = '0;
    w_pin_we   = 1'b0;
    if (!w_abort) begin
      case (state_q)
        ST_IDLE: tries_d = '0;
        ST_LANG: lang_d  = bus.Language;
        ST_PIN: begin
          if (w_pin_ok) begin
            tries_d = '0;
            src_d   = w_a_idx;
          end else begin
            tries_d = tries_q + TRY_W'(1);
          end
        end
        ST_BAL: status_d.bal = 1'b1;
        ST_WDR: begin
          if (w_wdr_ok) begin
            w_bal_we_a   = 1'b1;
            w_bal_a      = w_src_bal - bus.withdraw_amount;
            status_d.wdr = 1'b1;
          end
        end
        ST_DEP: begin
          if (!bus.money_counting && w_dep_ok) begin
            w_bal_we_a   = 1'b1;
            w_bal_a      = w_dep_sum[AMT_W-1:0];
            status_d.dep = 1'b1;
          end
        end
        ST_XFR: begin
          if (w_xfr_ok) begin
            w_bal_we_a   = 1'b1;
            w_bal_a      = w_src_bal - bus.Transfer_Amount;
            w_bal_we_b   = 1'b1;
            w_bal_b      = w_xfr_sum[AMT_W-1:0];
            status_d.xfr = 1'b1;
          end
        end
        ST_CPIN: begin
          if (w_cpin_ok) begin
            w_pin_we     = 1'b1;
            status_d.pin = 1'b1;
          end
        end
        ST_RCPT:   status_d.rcpt = bus.take_receipt;
        ST_FINISH: status_d.fin  = 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.Transfer_Successfully    = status_q.xfr;
  assign bus.ATM_Usage_Finished       = status_q.fin;
  assign bus.Balance_Shown            = status_q.bal;
  assign bus.Deposited_Successfully   = status_q.dep;
  assign bus.Withdrew_Successfully    = status_q.wdr;
  assign bus.Pin_Changed_Successfully = status_q.pin;
  assign bus.Receipt_Printed          = status_q.rcpt;

endmodule
`default_nettype wire

// File: tb/tb_atm.sv
`default_nettype none
// ==========================================================================
// tb_atm : directed + randomized sessions checked against an account model
// Rev 1.0
// ==========================================================================
module tb_atm;

  localparam int          N        = 4;
  localparam int          MAXT     = 3;
  localparam int          BAL_MAX  = 524287;
  localparam logic [6:0]  P_NONE = 7'b0000000;
  localparam logic [6:0]  P_XFR  = 7'b1000000;
  localparam logic [6:0]  P_FIN  = 7'b0100000;
  localparam logic [6:0]  P_BAL  = 7'b0010000;
  localparam logic [6:0]  P_DEP  = 7'b0001000;
  localparam logic [6:0]  P_WDR  = 7'b0000100;
  localparam logic [6:0]  P_PIN  = 7'b0000010;
  localparam logic [6:0]  P_RCP  = 7'b0000001;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  atm_if bus ();

  atm dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [6:0] w_outs;
  assign w_outs = {bus.Transfer_Successfully, bus.ATM_Usage_Finished, bus.Balance_Shown,
                   bus.Deposited_Successfully, bus.Withdrew_Successfully,
                   bus.Pin_Changed_Successfully, bus.Receipt_Printed};

  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [18:0] m_bal [N];
  logic [16:0] m_pin [N];
  int          m_tries;
  int          m_src;
  int          m_total;
  bit          in_menu, done;
  logic [16:0] acc, pwd;
  int          nops;

  function automatic int acc_idx(input logic [16:0] num);
    if (num >= 17'd1000 && num < 17'(1000 + N)) return int'(num) - 1000;
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [6:0] exp);
    n_cmp++;
    assert (w_outs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, w_outs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_bal[i] = 19'd50000;
      m_pin[i] = 17'(1234 + i);
    end
    m_tries = 0;
    m_total = 0;
  endtask

  task automatic clear_inputs();
    bus.Card_in = 0; bus.Language = 0; bus.Timer = 0; bus.money_counting = 0;
    bus.another_transaction_bit = 0; bus.opcode = 0; bus.password = 0; bus.new_pin = 0;
    bus.allowwithdraw = 0; bus.take_receipt = 0; bus.allow_transfer = 0;
    bus.Pers_Account_No = 0; bus.ur_account = 0; bus.withdraw_amount = 0;
    bus.Transfer_Amount = 0; bus.deposit_amount = 0;
  endtask

  task automatic begin_session();
    m_tries = 0;
    m_total = 0;
    bus.Card_in  = 1;
    bus.Language = 1'($urandom_range(0, 1));
    tick(); check("card_insert", P_NONE);
    tick(); check("language", P_NONE);
  endtask

  task automatic try_pin(input logic [16:0] num, input logic [16:0] pw,
                         output bit ok, output bit fin);
    int idx;
    idx = acc_idx(num);
    bus.Pers_Account_No = num;
    bus.password        = pw;
    tick(); check("pin_entry", P_NONE);
    ok  = (idx >= 0) && (pw == m_pin[idx]);
    fin = 0;
    if (ok) begin
      m_tries = 0;
      m_src   = idx;
    end else begin
      m_tries++;
      if (m_tries >= MAXT) begin
        fin = 1;
        tick(); check("pin_lockout", P_FIN);
      end
    end
  endtask

  task automatic card_out();
    clear_inputs();
    tick(); check("idle", P_NONE);
  endtask

  task automatic op_select(input logic [2:0] op);
    bus.opcode = op;
    tick(); check("menu_select", P_NONE);
  endtask

  task automatic finish_op(input bit take, input bit another);
    bus.take_receipt = take;
    tick(); check("receipt", take ? P_RCP : P_NONE);
    bus.another_transaction_bit = another;
    tick(); check("more", P_NONE);
    if (!another) begin
      tick(); check("finished", P_FIN);
    end
  endtask

  task automatic op_balance();
    op_select(3'd0);
    tick(); check("balance", P_BAL);
  endtask

  task automatic op_withdraw(input logic [18:0] amt, input bit allow);
    bit ok;
    op_select(3'd1);
    bus.withdraw_amount = amt;
    bus.allowwithdraw   = allow;
    ok = allow && (amt != 0) && (amt <= m_bal[m_src]);
`ifdef ATM_DAILY_LIMIT_EN
    ok = ok && (m_total + int'(amt) <= 20000);
`endif
    tick(); check("withdraw", ok ? P_WDR : P_NONE);
    if (ok) begin
      m_bal[m_src] = m_bal[m_src] - amt;
      m_total      = m_total + int'(amt);
    end
  endtask

  task automatic op_deposit(input logic [18:0] amt, input int count_cycles);
    bit ok;
    op_select(3'd2);
    bus.deposit_amount = amt;
    bus.money_counting = 1;
    for (int c = 0; c < count_cycles; c++) begin
      tick(); check("deposit_counting", P_NONE);
    end
    bus.money_counting = 0;
    ok = (amt != 0) && (int'(m_bal[m_src]) + int'(amt) <= BAL_MAX);
    tick(); check("deposit", ok ? P_DEP : P_NONE);
    if (ok) m_bal[m_src] = m_bal[m_src] + amt;
  endtask

  task automatic op_transfer(input logic [16:0] dst, input logic [18:0] amt, input bit allow);
    bit ok;
    int d;
    d = acc_idx(dst);
    op_select(3'd3);
    bus.ur_account      = dst;
    bus.Transfer_Amount = amt;
    bus.allow_transfer  = allow;
    ok = allow && (d >= 0) && (d != m_src) && (amt != 0) && (amt <= m_bal[m_src]);
    if (ok) ok = (int'(m_bal[d]) + int'(amt) <= BAL_MAX);
    tick(); check("transfer", ok ? P_XFR : P_NONE);
    if (ok) begin
      m_bal[m_src] = m_bal[m_src] - amt;
      m_bal[d]     = m_bal[d] + amt;
    end
  endtask

  task automatic op_cpin(input logic [16:0] np);
    bit ok;
    op_select(3'd4);
    bus.new_pin = np;
    ok = (np != 0) && (np != m_pin[m_src]);
    tick(); check("change_pin", ok ? P_PIN : P_NONE);
    if (ok) m_pin[m_src] = np;
  endtask

  task automatic login(input logic [16:0] num);
    bit ok, fin;
    int idx;
    idx = acc_idx(num);
    begin_session();
    try_pin(num, (idx >= 0) ? m_pin[idx] : 17'd0, ok, fin);
    assert (ok) else $fatal(1, "FAIL login_setup: account %0d rejected by model", num);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    clear_inputs();
    model_reset();
    reset = 1;
    repeat (2) @(negedge clk);
    check("reset_hold", P_NONE);
    reset = 0;
    tick(); check("reset_release", P_NONE);

    // Balance enquiry with receipt on account 1000
    login(17'd1000);
    op_balance();
    finish_op(1, 0);
    card_out();

    // Withdraw boundaries on 1001
    login(17'd1001);
    op_withdraw(19'd20000, 1); finish_op(0, 1);
    op_withdraw(19'd40000, 1); finish_op(0, 1);
    op_withdraw(19'd30000, 1); finish_op(0, 1);
    op_withdraw(19'd0, 1);     finish_op(0, 1);
    op_deposit(19'd30000, 4);  finish_op(1, 0);
    card_out();

    // Transfers from 1000, including rejected ones and an unused opcode
    login(17'd1000);
    op_transfer(17'd1002, 19'd10000, 1); finish_op(1, 1);
    op_transfer(17'd1000, 19'd10000, 1); finish_op(0, 1);
    op_transfer(17'd1009, 19'd100, 1);   finish_op(0, 1);
    op_transfer(17'd1001, 19'd100, 0);   finish_op(0, 1);
    op_select(3'd5);
    op_balance();
    finish_op(0, 0);
    card_out();

    // Three wrong PINs lock the session out
    begin_session();
    for (int t = 0; t < MAXT; t++) try_pin(17'd1000, 17'd0, in_menu, done);
    card_out();

    // Deposit after counting, PIN changes, timeout from MENU
    login(17'd1003);
    op_deposit(19'd5000, 4); finish_op(0, 1);
    op_cpin(17'd0);          finish_op(0, 1);
    op_cpin(17'd1237);       finish_op(0, 1);
    op_cpin(17'd4321);       finish_op(0, 1);
    bus.Timer = 1;
    tick(); check("timeout_menu", P_NONE);
    tick(); check("timeout_finish", P_FIN);
    card_out();

    // Old PIN rejected, new PIN accepted, deposit overflow boundary
    begin_session();
    try_pin(17'd1003, 17'd1237, in_menu, done);
    try_pin(17'd1003, 17'd4321, in_menu, done);
    op_deposit(19'(BAL_MAX - int'(m_bal[m_src]) + 1), 0); finish_op(0, 1);
    op_deposit(19'(BAL_MAX - int'(m_bal[m_src])), 1);     finish_op(0, 0);
    card_out();

    // Destination overflow and exact-balance transfer
    login(17'd1000);
    op_transfer(17'd1003, 19'd1, 1);           finish_op(0, 1);
    op_transfer(17'd1001, m_bal[m_src], 1);    finish_op(0, 1);
    op_withdraw(19'd1, 1);                     finish_op(0, 0);
    card_out();

    // Card pulled while in WDR: no commit, full balance still withdrawable
    login(17'd1002);
    op_select(3'd1);
    bus.withdraw_amount = 19'd100;
    bus.allowwithdraw   = 1;
    bus.Card_in         = 0;
    tick(); check("card_pull_wdr", P_NONE);
    tick(); check("card_pull_finish", P_FIN);
    card_out();
    login(17'd1002);
    op_withdraw(m_bal[m_src], 1); finish_op(0, 0);
    card_out();

    // Randomized sessions
    for (int s = 0; s < 30; s++) begin
      acc = 17'(1000 + $urandom_range(0, N));
      begin_session();
      in_menu = 0;
      done    = 0;
      while (!in_menu && !done) begin
        if (acc_idx(acc) >= 0 && $urandom_range(0, 3) != 0) pwd = m_pin[acc_idx(acc)];
        else pwd = 17'($urandom);
        try_pin(acc, pwd, in_menu, done);
      end
      if (in_menu) begin
        nops = $urandom_range(1, 4);
        for (int k = 0; k < nops; k++) begin
          case ($urandom_range(0, 4))
            0: op_balance();
            1: op_withdraw(($urandom_range(0, 7) == 0) ? m_bal[m_src]
                                                        : 19'($urandom_range(0, 70000)),
                           $urandom_range(0, 3) != 0);
            2: op_deposit(($urandom_range(0, 7) == 0) ? 19'd0
                                                       : 19'($urandom_range(0, 200000)),
                          $urandom_range(0, 3));
            3: op_transfer(17'(1000 + $urandom_range(0, N)),
                           19'($urandom_range(0, 80000)), $urandom_range(0, 3) != 0);
            default: op_cpin(($urandom_range(0, 3) == 0) ? m_pin[m_src] : 17'($urandom));
          endcase
          finish_op(1'($urandom_range(0, 1)), k != nops - 1);
        end
      end
      card_out();
    end

    // Asynchronous reset mid-session restores the table
    login(17'd1001);
    #2 reset = 1;
    #1 check("async_reset", P_NONE);
    clear_inputs();
    model_reset();
    @(negedge clk);
    reset = 0;
    tick(); check("after_async_reset", P_NONE);
    login(17'd1003);
    op_withdraw(19'd50000, 1); finish_op(1, 0);
    card_out();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/atm.md
Name: atm

Overview:
Single-clock ATM session controller.
- Holds a small internal account table (number, PIN, balance).
- Sequences one card session: card insert, language, PIN check, transaction menu, optional receipt, repeat or finish.
- Reports each completed action on one-cycle registered status pulses.
- Sits behind the front-panel/keypad logic, which supplies already-decoded operands.

Parameters:
NUM_ACCOUNTS, 4, number of table entries (power of two, 2..16).
ACC_BASE, 17'd1000, entry i account number = ACC_BASE+i.
PIN_BASE, 17'd1234, entry i reset PIN = PIN_BASE+i.
INIT_BALANCE, 19'd50000, every entry's balance after reset.
MAX_PIN_TRIES, 3, wrong-PIN attempts before the session is aborted.

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-high; clears FSM, table and outputs
Card_in  in  1  card present level
Language  in  1  0=English, 1=Arabic; latched, no functional effect
Timer  in  1  inactivity timeout, abort session
money_counting  in  1  1 = deposit notes still being counted
another_transaction_bit  in  1  1 = return to menu after transaction
opcode  in  3  000 balance, 001 withdraw, 010 deposit, 011 transfer, 100 change PIN
password  in  17  entered PIN
new_pin  in  17  replacement PIN
allowwithdraw  in  1  withdraw authorisation
take_receipt  in  1  user requests receipt
allow_transfer  in  1  transfer authorisation
Pers_Account_No  in  17  session (source) account number
ur_account  in  17  transfer destination account number
withdraw_amount  in  19  unsigned amount
Transfer_Amount  in  19  unsigned amount
deposit_amount  in  19  unsigned amount
Transfer_Successfully, ATM_Usage_Finished, Balance_Shown, Deposited_Successfully, Withdrew_Successfully, Pin_Changed_Successfully, Receipt_Printed  out  1 each  registered status pulses

Behaviour:
- Reset: state IDLE; all seven outputs 0; tries=0; table restored to parameter values.
- Outputs are registered and high for exactly one cycle, in the cycle after the edge where the action commits.
- All outputs are 0 otherwise, including the first cycle after reset.

FSM states and transitions (inputs are sampled every rising edge):
- IDLE: rising edge of Card_in (previous-cycle register) -> LANG.
- LANG: latch Language -> PIN.
- PIN: lookup Pers_Account_No.
  - Account found and password equals stored PIN: tries=0, latch source index -> MENU.
  - Otherwise: tries+1; reaching MAX_PIN_TRIES -> FINISH, else stay in PIN.
- MENU: opcode 000..100 -> BAL/WDR/DEP/XFR/CPIN; opcode 101..111 -> stay in MENU.
- BAL: pulse Balance_Shown -> RCPT.
- WDR: succeeds when allowwithdraw=1, amount != 0 and amount <= balance.
  - Success: balance -= amount, pulse Withdrew_Successfully.
  - Failure: balance unchanged, no pulse.
  - Either way -> RCPT.
- DEP: wait in DEP while money_counting=1.
  - Then, if amount != 0 and balance+amount <= 2^19-1: add amount, pulse Deposited_Successfully.
  - Either way -> RCPT.
- XFR: succeeds when allow_transfer=1, ur_account exists, destination != source, amount != 0, amount <= source balance, and destination does not overflow.
  - Success: both balances update on the same edge, pulse Transfer_Successfully.
  - Either way -> RCPT.
- CPIN: if new_pin != 0 and new_pin != current PIN: store it, pulse Pin_Changed_Successfully. -> RCPT.
- RCPT: if take_receipt=1, pulse Receipt_Printed. -> MORE.
- MORE: another_transaction_bit=1 -> MENU, else FINISH.
- FINISH: pulse ATM_Usage_Finished -> IDLE.

Abort rule:
- In any state other than IDLE/FINISH, Timer=1 or Card_in=0 -> FINISH.
- Abort has priority over all other transitions.
- An operation aborted this way does not commit.

Arithmetic: unsigned 19-bit only; failed checks never modify the table.

Optional Feature:
ATM_DAILY_LIMIT_EN
- Defined: parameter DAILY_LIMIT (default 19'd20000). A per-session withdrawn-total register, cleared in IDLE, is checked.
  - A withdraw also fails if total+amount > DAILY_LIMIT.
  - On success, total += amount.
- Undefined: no limit, no extra register.

Decomposition:
- Package atm_pkg: state enum; opcode localparams (OP_BAL, OP_WDR, OP_DEP, OP_XFR, OP_CPIN); width constants ACC_W=17, PIN_W=17, AMT_W=19.
- Sub-module atm_account_table: parameterised register file.
  - Two combinational lookups (number -> hit, index).
  - Synchronous writes: one balance-pair write plus one PIN write.
- FSM stays in atm.

Test Plan:
- Reset asserted, then released with all inputs 0 -> all seven outputs 0 at the first negedge; state IDLE.
- Card_in rises, Pers_Account_No=1000, password=1234, opcode=000, take_receipt=1, another=0 -> Balance_Shown pulse, then Receipt_Printed, then ATM_Usage_Finished.
- Account 1001 with PIN 1235, allowwithdraw=1, withdraw 20000 -> Withdrew_Successfully. Then withdraw 40000 -> no pulse, balance stays 30000.
- Transfer 1000->1002, amount 10000, allow_transfer=1 -> Transfer_Successfully; balances 40000/60000. Retry with ur_account=1000 -> no pulse.
- Password 0 held three cycles in PIN -> FINISH, ATM_Usage_Finished, no MENU.
- Deposit 5000 with money_counting=1 for 4 cycles then 0 -> one Deposited_Successfully after release. Timer=1 mid-MENU -> ATM_Usage_Finished next cycle.
